ysyx_23060136_wbu_csr_commit: RTL and testbench
===============================================

// Module: ysyx_23060136_wbu_csr_commit
// PURPOSE
//  WBU-stage CSR write sequencer, directly upstream of IDU_CSR_FILE. Latches one retiring
//  instruction from MEM (valid/ready) and turns CSRRW/RS/RC, ECALL and MRET into the file's
//  two write channels (CSRWr_1/2, WBU_csr_rd_1/2, csr_busW_1/2). ECALL needs 3 writes, so it spans 2 cycles.
// PARAMETERS
//  BITS_W   64  data width; equals `ysyx_23060136_BITS_W
//  CSR_W    3   CSR index width; equals `ysyx_23060136_CSR_W (compact index, not 12-bit addr)
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       reset, asynchronous, active-high
//  MEM_valid       in   1       MEM holds a retiring instr
//  WBU_ready       out  1       WBU accepts this cycle (transfer = MEM_valid & WBU_ready)
//  MEM_pc          in   BITS_W  pc of instr (mepc source)
//  MEM_csr_op      in   3       csr_op_e: NONE,RW,RS,RC,ECALL,MRET
//  MEM_csr_idx     in   CSR_W   target CSR index (RW/RS/RC)
//  MEM_csr_rdata   in   BITS_W  old CSR value read in IDU (mstatus for ECALL/MRET)
//  MEM_csr_src     in   BITS_W  rs1 data or zero-extended zimm
//  MEM_cause       in   BITS_W  mcause value for ECALL (11 = M-mode ecall)
//  CSRWr_1/2       out  1       write enables, channel 1 / 2
//  WBU_csr_rd_1/2  out  CSR_W   write indices
//  csr_busW_1/2    out  BITS_W  write data
//  WBU_commit      out  1       1-cycle pulse: instr's last CSR write issued
//  WBU_csr_illegal out  1       1-cycle pulse: write to read-only CSR suppressed
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0 except WBU_ready=1; holding regs cleared.
//  States: IDLE, WB1, WB2. Transfer in IDLE or WB1 -> WB1 next cycle (op latched).
//  WB1 drives writes for the latched op combinationally from holding regs:
//   RW: ch1 idx<=src. RS: ch1 rdata|src. RC: ch1 rdata&~src. ch2 off.
//   RS/RC with src==0: no write (spec-mandated, no side effect), still commit.
//   idx == mvendorid/marchid with any write: no write, WBU_csr_illegal=1, commit.
//   ECALL: ch1 mepc<=pc, ch2 mcause<=cause; next state WB2, no commit yet.
//   MRET: ch1 mstatus<=rdata with MIE<=MPIE(bit7), MPIE<=1, MPP(12:11)<=2'b11.
//   NONE: no writes, commit.
//  WB2 (ECALL only): ch1 mstatus<=rdata with MPIE<=MIE(bit3), MIE<=0, MPP<=2'b11; commit.
//  WBU_ready = (state==IDLE) | (state==WB1 & op!=ECALL); 0 in WB2 -> back-to-back non-ECALL
//   ops at 1/cycle; ECALL costs 1 bubble.
//  WB1 with no new transfer -> IDLE; WB2 -> WB1 if transfer else IDLE (ready=0 so IDLE).
//  Channel 1 has priority in the file; block never drives ch1 and ch2 to same idx.
//  Latency: write visible in CSR file 2 cycles after transfer (WB1 drive, file edge).
//  Reset mid-ECALL (in WB2): abandon; mstatus not updated; no commit pulse.
//  MEM_valid with ready=0: inputs ignored, MEM must hold.
//  Illegal/unknown csr_op encodings treated as NONE.
// STRUCTURE
//  Package ysyx_23060136_csr_pkg: csr_op_e enum, state_e, CSR index constants
//   (mstatus, mtvec, mepc, mcause, mvendorid, marchid), mstatus bit positions, is_ro() func.
//  One sub-module natural: ysyx_23060136_mstatus_upd (pure comb: old, is_trap -> new mstatus),
//   shared with any future interrupt path.
// TESTING
//  Reset: assert rst async mid-cycle -> WBU_ready=1, CSRWr_1/2=0 immediately.
//  CSRRS mtvec, rdata=0x100, src=0x3 -> WB1: CSRWr_1=1, idx=mtvec, busW_1=0x103, commit=1.
//  CSRRC src=0 -> no CSRWr, commit=1; CSRRW marchid -> no write, illegal=1.
//  ECALL pc=0x8000_0010, cause=11, rdata=0xa00001808 -> WB1: mepc=0x8000_0010, mcause=11;
//   WB2: mstatus=0xa00001880, commit=1; WBU_ready=0 in WB1 and WB2.
//  MRET rdata=0xa00001880 -> mstatus=0xa00001888 in one cycle.
//  3 back-to-back CSRRW (MEM_valid held) -> 3 commits on 3 consecutive cycles; rst in WB2 -> no commit.

Source files
------------

// File: rtl/ysyx_23060136_csr_pkg.sv
// Shared types and constants for the WBU CSR write sequencer and the CSR file.
// The CSR index is the compact internal index, not the 12-bit architectural address.
package ysyx_23060136_csr_pkg;

   localparam int CSR_BITS_W = 64;
   localparam int CSR_IDX_W  = 3;

   typedef enum logic [2:0] {
      CSR_NONE  = 3'd0,
      CSR_RW    = 3'd1,
      CSR_RS    = 3'd2,
      CSR_RC    = 3'd3,
      CSR_ECALL = 3'd4,
      CSR_MRET  = 3'd5
   } csr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB1  = 2'd1,
      ST_WB2  = 2'd2
   } state_e;

   localparam logic [CSR_IDX_W-1:0] CSR_MSTATUS   = 3'd0;
   localparam logic [CSR_IDX_W-1:0] CSR_MTVEC     = 3'd1;
   localparam logic [CSR_IDX_W-1:0] CSR_MEPC      = 3'd2;
   localparam logic [CSR_IDX_W-1:0] CSR_MCAUSE    = 3'd3;
   localparam logic [CSR_IDX_W-1:0] CSR_MVENDORID = 3'd4;
   localparam logic [CSR_IDX_W-1:0] CSR_MARCHID   = 3'd5;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   function automatic logic is_ro(input logic [CSR_IDX_W-1:0] idx);
      return (idx == CSR_MVENDORID) || (idx == CSR_MARCHID);
   endfunction

   // Unused encodings collapse to NONE so they retire without side effects.
   function automatic csr_op_e decode_op(input logic [2:0] raw);
      csr_op_e op;
      case (raw)
         3'd1:    op = CSR_RW;
         3'd2:    op = CSR_RS;
         3'd3:    op = CSR_RC;
         3'd4:    op = CSR_ECALL;
         3'd5:    op = CSR_MRET;
         default: op = CSR_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ysyx_23060136_mstatus_upd.sv
// Pure combinational mstatus transform for trap entry (is_trap_i=1) and MRET (is_trap_i=0).
// Kept separate so an interrupt-entry path can reuse the same update.
module ysyx_23060136_mstatus_upd
   import ysyx_23060136_csr_pkg::*;
#(
   parameter int BITS_W = CSR_BITS_W
) (
   input  logic [BITS_W-1:0] old_i,
   input  logic              is_trap_i,
   output logic [BITS_W-1:0] new_o
);

   always_comb begin
      new_o = old_i;
      new_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      if (is_trap_i) begin
         new_o[MSTATUS_MPIE] = old_i[MSTATUS_MIE];
         new_o[MSTATUS_MIE]  = 1'b0;
      end else begin
         new_o[MSTATUS_MIE]  = old_i[MSTATUS_MPIE];
         new_o[MSTATUS_MPIE] = 1'b1;
      end
   end

endmodule

// File: rtl/ysyx_23060136_wbu_csr_commit.sv
// WBU-stage CSR write sequencer: latches one retiring instruction and drives the CSR
// file's two write channels; ECALL needs three writes and therefore spans WB1 and WB2.
//
// state | meaning
// IDLE  | no latched instruction, ready for a transfer
// WB1   | latched op drives its (first) writes; commits unless ECALL
// WB2   | ECALL second cycle: mstatus trap update, commit
module ysyx_23060136_wbu_csr_commit
   import ysyx_23060136_csr_pkg::*;
#(
   parameter int BITS_W = CSR_BITS_W,
   parameter int CSR_W  = CSR_IDX_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MEM_valid_i,
   output logic              WBU_ready_o,
   input  logic [BITS_W-1:0] MEM_pc_i,
   input  logic [2:0]        MEM_csr_op_i,
   input  logic [CSR_W-1:0]  MEM_csr_idx_i,
   input  logic [BITS_W-1:0] MEM_csr_rdata_i,
   input  logic [BITS_W-1:0] MEM_csr_src_i,
   input  logic [BITS_W-1:0] MEM_cause_i,
   output logic              CSRWr_1_o,
   output logic              CSRWr_2_o,
   output logic [CSR_W-1:0]  WBU_csr_rd_1_o,
   output logic [CSR_W-1:0]  WBU_csr_rd_2_o,
   output logic [BITS_W-1:0] csr_busW_1_o,
   output logic [BITS_W-1:0] csr_busW_2_o,
   output logic              WBU_commit_o,
   output logic              WBU_csr_illegal_o
);

   state_e            state_q, state_d;
   csr_op_e           op_q;
   logic [CSR_W-1:0]  idx_q;
   logic [BITS_W-1:0] pc_q;
   logic [BITS_W-1:0] rdata_q;
   logic [BITS_W-1:0] src_q;
   logic [BITS_W-1:0] cause_q;

   logic              xfer;
   logic              is_trap;
   logic              want_wr;
   logic [BITS_W-1:0] rmw_data;
   logic [BITS_W-1:0] mstatus_new;

   assign WBU_ready_o = (state_q == ST_IDLE) ||
                        ((state_q == ST_WB1) && (op_q != CSR_ECALL));
   assign xfer        = MEM_valid_i & WBU_ready_o;
   assign is_trap     = (state_q == ST_WB2);

   ysyx_23060136_mstatus_upd #(
      .BITS_W (BITS_W)
   ) u_mstatus_upd (
      .old_i     (rdata_q),
      .is_trap_i (is_trap),
      .new_o     (mstatus_new)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (xfer) state_d = ST_WB1;
         ST_WB1: begin
            if (op_q == CSR_ECALL) state_d = ST_WB2;
            else if (xfer)         state_d = ST_WB1;
            else                   state_d = ST_IDLE;
         end
         ST_WB2:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         op_q    <= CSR_NONE;
         idx_q   <= '0;
         pc_q    <= '0;
         rdata_q <= '0;
         src_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            op_q    <= decode_op(MEM_csr_op_i);
            idx_q   <= MEM_csr_idx_i;
            pc_q    <= MEM_pc_i;
            rdata_q <= MEM_csr_rdata_i;
            src_q   <= MEM_csr_src_i;
            cause_q <= MEM_cause_i;
         end
      end
   end

   // RS/RC with a zero mask never write, so they cannot trip the read-only check.
   always_comb begin
      case (op_q)
         CSR_RS:  rmw_data = rdata_q | src_q;
         CSR_RC:  rmw_data = rdata_q & ~src_q;
         default: rmw_data = src_q;
      endcase
      want_wr = (op_q == CSR_RW) || (src_q != '0);
   end

   always_comb begin
      CSRWr_1_o         = 1'b0;
      CSRWr_2_o         = 1'b0;
      WBU_csr_rd_1_o    = '0;
      WBU_csr_rd_2_o    = '0;
      csr_busW_1_o      = '0;
      csr_busW_2_o      = '0;
      WBU_commit_o      = 1'b0;
      WBU_csr_illegal_o = 1'b0;
      case (state_q)
         ST_WB1: begin
            case (op_q)
               CSR_RW, CSR_RS, CSR_RC: begin
                  WBU_commit_o = 1'b1;
                  if (want_wr && is_ro(idx_q)) begin
                     WBU_csr_illegal_o = 1'b1;
                  end else if (want_wr) begin
                     CSRWr_1_o      = 1'b1;
                     WBU_csr_rd_1_o = idx_q;
                     csr_busW_1_o   = rmw_data;
                  end
               end
               CSR_ECALL: begin
                  CSRWr_1_o      = 1'b1;
                  WBU_csr_rd_1_o = CSR_MEPC;
                  csr_busW_1_o   = pc_q;
                  CSRWr_2_o      = 1'b1;
                  WBU_csr_rd_2_o = CSR_MCAUSE;
                  csr_busW_2_o   = cause_q;
               end
               CSR_MRET: begin
                  CSRWr_1_o      = 1'b1;
                  WBU_csr_rd_1_o = CSR_MSTATUS;
                  csr_busW_1_o   = mstatus_new;
                  WBU_commit_o   = 1'b1;
               end
               default: WBU_commit_o = 1'b1;
            endcase
         end
         ST_WB2: begin
            CSRWr_1_o      = 1'b1;
            WBU_csr_rd_1_o = CSR_MSTATUS;
            csr_busW_1_o   = mstatus_new;
            WBU_commit_o   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060136_wbu_csr_commit.sv
// Self-checking bench: table of vectors applied back-to-back and with gaps through a
// scoreboard queue, plus hand-written reset sequences.
module tb_ysyx_23060136_wbu_csr_commit;
   import ysyx_23060136_csr_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MEM_valid = 1'b0;
   logic        WBU_ready;
   logic [63:0] MEM_pc = '0;
   logic [2:0]  MEM_csr_op = '0;
   logic [2:0]  MEM_csr_idx = '0;
   logic [63:0] MEM_csr_rdata = '0;
   logic [63:0] MEM_csr_src = '0;
   logic [63:0] MEM_cause = '0;
   logic        CSRWr_1, CSRWr_2;
   logic [2:0]  rd_1, rd_2;
   logic [63:0] busW_1, busW_2;
   logic        commit, illegal;

   ysyx_23060136_wbu_csr_commit dut (
      .clk_i(clk), .rst_i(rst), .MEM_valid_i(MEM_valid), .WBU_ready_o(WBU_ready),
      .MEM_pc_i(MEM_pc), .MEM_csr_op_i(MEM_csr_op), .MEM_csr_idx_i(MEM_csr_idx),
      .MEM_csr_rdata_i(MEM_csr_rdata), .MEM_csr_src_i(MEM_csr_src), .MEM_cause_i(MEM_cause),
      .CSRWr_1_o(CSRWr_1), .CSRWr_2_o(CSRWr_2), .WBU_csr_rd_1_o(rd_1), .WBU_csr_rd_2_o(rd_2),
      .csr_busW_1_o(busW_1), .csr_busW_2_o(busW_2), .WBU_commit_o(commit),
      .WBU_csr_illegal_o(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  idx;
      logic [63:0] rdata;
      logic [63:0] src;
      logic [63:0] pc;
      logic [63:0] cause;
   } stim_t;

   typedef struct {
      logic        wr1;
      logic [2:0]  idx1;
      logic [63:0] bus1;
      logic        wr2;
      logic [2:0]  idx2;
      logic [63:0] bus2;
      logic        commit;
      logic        illegal;
      logic        ready;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e1;
      bit    two;
      exp_t  e2;
   } vec_t;

   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];
   vec_t vecs[16];

   function automatic stim_t st(logic [2:0] op, logic [2:0] idx, logic [63:0] rdata,
                                logic [63:0] src, logic [63:0] pc, logic [63:0] cause);
      stim_t s;
      s.op = op; s.idx = idx; s.rdata = rdata; s.src = src; s.pc = pc; s.cause = cause;
      return s;
   endfunction

   function automatic exp_t ex(logic wr1, logic [2:0] idx1, logic [63:0] bus1, logic wr2,
                               logic [2:0] idx2, logic [63:0] bus2, logic cm, logic il,
                               logic rdy);
      exp_t e;
      e.wr1 = wr1; e.idx1 = idx1; e.bus1 = bus1; e.wr2 = wr2; e.idx2 = idx2; e.bus2 = bus2;
      e.commit = cm; e.illegal = il; e.ready = rdy;
      return e;
   endfunction

   function automatic logic [138:0] pk(exp_t e);
      return {e.wr1, e.idx1, e.bus1, e.wr2, e.idx2, e.bus2, e.commit, e.illegal, e.ready};
   endfunction

   function automatic logic [138:0] act();
      return {CSRWr_1, rd_1, busW_1, CSRWr_2, rd_2, busW_2, commit, illegal, WBU_ready};
   endfunction

   task automatic cmp(input string name, input logic [138:0] a, input logic [138:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   exp_t idle_e;
   initial idle_e = ex(0, 0, 0, 0, 0, 0, 0, 0, 1);

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) cmp("scoreboard", act(), pk(exp_q.pop_front()));
         else                  cmp("idle", act(), pk(idle_e));
      end
   end

   task automatic send(input vec_t v, input bit gap);
      int t;
      MEM_valid     = 1'b1;
      MEM_csr_op    = v.s.op;
      MEM_csr_idx   = v.s.idx;
      MEM_csr_rdata = v.s.rdata;
      MEM_csr_src   = v.s.src;
      MEM_pc        = v.s.pc;
      MEM_cause     = v.s.cause;
      t = 0;
      while (!WBU_ready && t < 20) begin
         @(negedge clk); #1;
         t++;
      end
      if (!WBU_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
      end
      exp_q.push_back(v.e1);
      if (v.two) exp_q.push_back(v.e2);
      @(negedge clk); #1;
      if (gap) begin
         MEM_valid = 1'b0;
         @(negedge clk); #1;
      end
   endtask

   task automatic drain();
      MEM_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      cmp("queue_drained", 139'(exp_q.size()), 139'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{st(CSR_RS, CSR_MTVEC, 64'h100, 64'h3, 0, 0),
                   ex(1, CSR_MTVEC, 64'h103, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[1]  = '{st(CSR_RC, CSR_MEPC, 64'h55, 64'h0, 0, 0),
                   ex(0, 0, 0, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[2]  = '{st(CSR_RW, CSR_MARCHID, 64'h0, 64'h5, 0, 0),
                   ex(0, 0, 0, 0, 0, 0, 1, 1, 1), 0, idle_e};
      vecs[3]  = '{st(CSR_ECALL, CSR_MSTATUS, 64'ha00001808, 64'h0, 64'h8000_0010, 64'd11),
                   ex(1, CSR_MEPC, 64'h8000_0010, 1, CSR_MCAUSE, 64'd11, 0, 0, 0), 1,
                   ex(1, CSR_MSTATUS, 64'ha00001880, 0, 0, 0, 1, 0, 0)};
      vecs[4]  = '{st(CSR_MRET, CSR_MSTATUS, 64'ha00001880, 64'h0, 0, 0),
                   ex(1, CSR_MSTATUS, 64'ha00001888, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[5]  = '{st(CSR_RC, CSR_MCAUSE, 64'hff, 64'h0f, 0, 0),
                   ex(1, CSR_MCAUSE, 64'hf0, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[6]  = '{st(CSR_RW, CSR_MEPC, 64'h9, 64'h1234, 0, 0),
                   ex(1, CSR_MEPC, 64'h1234, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[7]  = '{st(CSR_NONE, CSR_MTVEC, 64'h9, 64'h7, 64'h44, 0),
                   ex(0, 0, 0, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[8]  = '{st(3'd7, CSR_MTVEC, 64'h9, 64'h7, 64'h44, 0),
                   ex(0, 0, 0, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[9]  = '{st(CSR_RS, CSR_MVENDORID, 64'h1, 64'h0, 0, 0),
                   ex(0, 0, 0, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[10] = '{st(CSR_RS, CSR_MVENDORID, 64'h1, 64'h1, 0, 0),
                   ex(0, 0, 0, 0, 0, 0, 1, 1, 1), 0, idle_e};
      vecs[11] = '{st(CSR_RW, CSR_MSTATUS, 64'hffff, 64'h0, 0, 0),
                   ex(1, CSR_MSTATUS, 64'h0, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[12] = '{st(CSR_MRET, CSR_MSTATUS, 64'h0, 64'h0, 0, 0),
                   ex(1, CSR_MSTATUS, 64'h1880, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[13] = '{st(CSR_RW, CSR_MTVEC, 64'h0, 64'haaaa, 0, 0),
                   ex(1, CSR_MTVEC, 64'haaaa, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[14] = '{st(CSR_RW, CSR_MEPC, 64'h0, 64'hbbbb, 0, 0),
                   ex(1, CSR_MEPC, 64'hbbbb, 0, 0, 0, 1, 0, 1), 0, idle_e};
      vecs[15] = '{st(CSR_RW, CSR_MCAUSE, 64'h0, 64'hcccc, 0, 0),
                   ex(1, CSR_MCAUSE, 64'hcccc, 0, 0, 0, 1, 0, 1), 0, idle_e};

      #3;
      cmp("reset_state", act(), pk(idle_e));
      @(negedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;

      mon_en = 1'b1;
      foreach (vecs[i]) send(vecs[i], 1'b0);
      drain();
      foreach (vecs[i]) send(vecs[i], 1'b1);
      drain();
      mon_en = 1'b0;
      @(negedge clk); #1;

      // Asynchronous reset mid-cycle while a CSRRW sits in WB1.
      MEM_valid = 1'b1; MEM_csr_op = CSR_RW; MEM_csr_idx = CSR_MTVEC; MEM_csr_src = 64'h77;
      @(negedge clk); #1;
      MEM_valid = 1'b0;
      cmp("wb1_before_rst", act(), pk(ex(1, CSR_MTVEC, 64'h77, 0, 0, 0, 1, 0, 1)));
      #2 rst = 1'b1;
      #1 cmp("async_rst_mid_cycle", act(), pk(idle_e));
      @(negedge clk); #1;
      rst = 1'b0;

      // Reset while an ECALL is in WB2: no commit afterwards.
      @(negedge clk); #1;
      MEM_valid = 1'b1; MEM_csr_op = CSR_ECALL; MEM_csr_rdata = 64'ha00001808;
      MEM_pc = 64'h8000_0010; MEM_cause = 64'd11;
      @(posedge clk); #1;
      MEM_valid = 1'b0;
      @(posedge clk); #1;
      cmp("wb2_entered", act(), pk(ex(1, CSR_MSTATUS, 64'ha00001880, 0, 0, 0, 1, 0, 0)));
      rst = 1'b1;
      #1 cmp("rst_in_wb2", act(), pk(idle_e));
      @(negedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      cmp("after_wb2_rst", act(), pk(idle_e));
      @(negedge clk); #1;
      cmp("after_wb2_rst_2", act(), pk(idle_e));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
